axi_burst_sched: RTL and testbench

//  Schedules i-cache line refills and d-cache refills/writebacks onto one AXI4 master port.

---
 rtl/axi_burst_sched_if.sv | 63 ++++++
 rtl/axi_burst_sched.sv | 190 +++++++++++++++++++
 tb/tb_axi_burst_sched.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_burst_sched_if.sv
// AXI4 master-port bundle used by axi_burst_sched (AR/AW/W/R/B channels).
// The scheduler ignores r_id/b_id, so only the slave side sees them.
interface axi_burst_sched_if;
  logic [3:0]  ar_id;
  logic [63:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        ar_valid;
  logic        ar_ready;

  logic [3:0]  aw_id;
  logic [63:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic        aw_valid;
  logic        aw_ready;

  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        w_last;
  logic        w_valid;
  logic        w_ready;

  logic [3:0]  r_id;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic        r_valid;
  logic        r_ready;

  logic [3:0]  b_id;
  logic [1:0]  b_resp;
  logic        b_valid;
  logic        b_ready;

  modport master (
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
    input  ar_ready,
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_valid,
    input  w_ready,
    input  r_data, r_resp, r_last, r_valid,
    output r_ready,
    input  b_resp, b_valid,
    output b_ready
  );

  modport slave (
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
    output ar_ready,
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_valid,
    output w_ready,
    output r_id, r_data, r_resp, r_last, r_valid,
    input  r_ready,
    output b_id, b_resp, b_valid,
    input  b_ready
  );
endinterface

// File: rtl/axi_burst_sched.sv
// Single-outstanding AXI4 burst scheduler for i-cache refills and d-cache refills/writebacks.
// Define AXI_SCHED_DPRIO_EN for fixed d-cache priority; default is round-robin arbitration.
//
// state | meaning
// IDLE  | waiting for a request; grant pulses req_ready and latches the command
// RADDR | AR valid with latched command until ar_ready
// RDATA | R beats forwarded to the owner until r_last
// WRITE | AW and W streamed independently until both complete
// WRESP | waiting for the B response
module axi_burst_sched #(
  parameter logic [7:0] I_LEN = 8'd7,
  parameter logic [3:0] ID_I  = 4'd0,
  parameter logic [3:0] ID_D  = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  input  logic [63:0] i_req_addr,
  output logic        i_req_ready,
  output logic [63:0] i_rdata,
  output logic        i_rvalid,
  output logic        i_rlast,
  input  logic        d_req_valid,
  input  logic        d_req_we,
  input  logic [63:0] d_req_addr,
  input  logic [7:0]  d_req_len,
  input  logic [2:0]  d_req_size,
  output logic        d_req_ready,
  input  logic [63:0] d_wdata,
  input  logic [7:0]  d_wstrb,
  output logic        d_wready,
  output logic [63:0] d_rdata,
  output logic        d_rvalid,
  output logic        d_rlast,
  output logic        d_bdone,
  output logic        err,
  axi_burst_sched_if.master axi
);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WRITE, WRESP} state_t;

  state_t      state_q, state_d;
  logic [63:0] addr_q;
  logic [7:0]  len_q;
  logic [2:0]  size_q;
  logic        own_d_q;
  logic [7:0]  cnt_q;
  logic        aw_done_q;
  logic        w_done_q;
  logic        rerr_q;

  logic grant_i, grant_d;
  logic w_hs, aw_all_done, w_all_done, r_bad;

`ifdef AXI_SCHED_DPRIO_EN
  assign grant_d = d_req_valid;
  assign grant_i = i_req_valid & ~d_req_valid;
`else
  logic last_d_q;

  // On a tie the requester that was not granted last time wins.
  assign grant_i = i_req_valid & (~d_req_valid | last_d_q);
  assign grant_d = d_req_valid & ~grant_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_d_q <= 1'b1;
    end else if (state_q == IDLE && (i_req_valid || d_req_valid)) begin
      last_d_q <= grant_d;
    end
  end
`endif

  assign w_hs        = axi.w_valid & axi.w_ready;
  assign aw_all_done = aw_done_q | (axi.aw_valid & axi.aw_ready);
  assign w_all_done  = w_done_q | (w_hs & axi.w_last);
  // A beat counter still above zero at r_last means the slave shortened the burst.
  assign r_bad       = rerr_q | (axi.r_resp != 2'b00) | (cnt_q != 8'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_i)      state_d = RADDR;
        else if (grant_d) state_d = d_req_we ? WRITE : RADDR;
      end
      RADDR: if (axi.ar_valid && axi.ar_ready) state_d = RDATA;
      RDATA: if (axi.r_valid && axi.r_last)    state_d = IDLE;
      WRITE: if (aw_all_done && w_all_done)    state_d = WRESP;
      WRESP: if (axi.b_valid)                  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      own_d_q   <= 1'b0;
      cnt_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rerr_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          rerr_q    <= 1'b0;
          if (grant_i) begin
            addr_q  <= i_req_addr;
            len_q   <= I_LEN;
            size_q  <= 3'b011;
            own_d_q <= 1'b0;
            cnt_q   <= I_LEN;
          end else if (grant_d) begin
            addr_q  <= d_req_addr;
            len_q   <= d_req_len;
            size_q  <= d_req_size;
            own_d_q <= 1'b1;
            cnt_q   <= d_req_len;
          end
        end
        RDATA: begin
          if (axi.r_valid) begin
            cnt_q <= cnt_q - 8'd1;
            if (axi.r_resp != 2'b00) rerr_q <= 1'b1;
          end
        end
        WRITE: begin
          if (axi.aw_valid && axi.aw_ready) aw_done_q <= 1'b1;
          if (w_hs) begin
            if (axi.w_last) w_done_q <= 1'b1;
            else            cnt_q    <= cnt_q - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    i_req_ready  = (state_q == IDLE) & grant_i;
    d_req_ready  = (state_q == IDLE) & grant_d;

    axi.ar_id    = own_d_q ? ID_D : ID_I;
    axi.ar_addr  = addr_q;
    axi.ar_len   = len_q;
    axi.ar_size  = size_q;
    axi.ar_burst = 2'b01;
    axi.ar_valid = (state_q == RADDR);

    axi.aw_id    = ID_D;
    axi.aw_addr  = addr_q;
    axi.aw_len   = len_q;
    axi.aw_size  = size_q;
    axi.aw_burst = 2'b01;
    axi.aw_valid = (state_q == WRITE) & ~aw_done_q;

    axi.w_data   = d_wdata;
    axi.w_strb   = d_wstrb;
    axi.w_last   = (cnt_q == 8'd0);
    axi.w_valid  = (state_q == WRITE) & ~w_done_q;
    d_wready     = w_hs;

    axi.r_ready  = (state_q == RDATA);
    i_rdata      = axi.r_data;
    d_rdata      = axi.r_data;
    i_rvalid     = (state_q == RDATA) & ~own_d_q & axi.r_valid;
    d_rvalid     = (state_q == RDATA) &  own_d_q & axi.r_valid;
    i_rlast      = i_rvalid & axi.r_last;
    d_rlast      = d_rvalid & axi.r_last;

    axi.b_ready  = (state_q == WRESP);
    d_bdone      = (state_q == WRESP) & axi.b_valid;

    err = ((state_q == RDATA) & axi.r_valid & axi.r_last & r_bad) |
          (d_bdone & (axi.b_resp != 2'b00));
  end

endmodule

// File: tb/tb_axi_burst_sched.sv
// Self-checking bench for axi_burst_sched: reset, arbitration ties, directed table, random traffic.
// The bench itself plays both cache clients and the AXI slave.
module tb_axi_burst_sched;
  localparam logic [7:0] I_LEN = 8'd7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        i_req_valid = 0, i_req_ready, i_rvalid, i_rlast;
  logic [63:0] i_req_addr = '0, i_rdata;
  logic        d_req_valid = 0, d_req_we = 0, d_req_ready, d_wready, d_rvalid, d_rlast, d_bdone, err;
  logic [63:0] d_req_addr = '0, d_wdata = '0, d_rdata;
  logic [7:0]  d_req_len = '0, d_wstrb = '0;
  logic [2:0]  d_req_size = 3'b011;

  axi_burst_sched_if axi();

  axi_burst_sched dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_rlast(i_rlast),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_req_len(d_req_len), .d_req_size(d_req_size), .d_req_ready(d_req_ready),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wready(d_wready),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_rlast(d_rlast),
    .d_bdone(d_bdone), .err(err), .axi(axi)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit model_last_d = 1'b1;

  typedef struct {
    bit          own_d;
    bit          we;
    logic [63:0] addr;
    logic [7:0]  len;
    int          ar_delay;
    int          aw_delay;
    int          b_delay;
    int          err_beat;
    int          early;
    logic [1:0]  bresp;
    int          exp_beats;
    bit          exp_err;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic request(input bit own_d, input bit we, input logic [63:0] addr,
                         input logic [7:0] len, output bit ok);
    ok = 1'b0;
    if (own_d) begin
      d_req_valid = 1; d_req_we = we; d_req_addr = addr; d_req_len = len; d_req_size = 3'b011;
    end else begin
      i_req_valid = 1; i_req_addr = addr;
    end
    for (int c = 0; c < 600 && !ok; c++) begin
      #1;
      if (own_d ? d_req_ready : i_req_ready) ok = 1'b1;
      else @(negedge clk);
    end
    chk("grant", 64'(ok), 64'd1);
    if (ok) begin
      chk("grant_other", 64'(own_d ? i_req_ready : d_req_ready), 64'd0);
      model_last_d = own_d;
    end
    @(negedge clk);
    if (own_d) d_req_valid = 0; else i_req_valid = 0;
  endtask

  task automatic serve_read(input bit own_d, input logic [63:0] addr, input logic [7:0] len,
                            input int ar_delay, input int err_beat, input int early, input bit gaps,
                            input int exp_beats, input bit exp_err);
    logic [7:0] exp_len;
    int last_idx, k, seen, cyc;
    exp_len  = own_d ? len : I_LEN;
    last_idx = (early >= 0) ? early : int'(exp_len);
    k = 0; seen = 0; cyc = 0;
    for (int c = 0; c <= ar_delay; c++) begin
      axi.ar_ready = (c == ar_delay);
      #1;
      chk("ar_valid", 64'(axi.ar_valid), 64'd1);
      if (c == ar_delay) begin
        chk("ar_addr", axi.ar_addr, addr);
        chk("ar_len", 64'(axi.ar_len), 64'(exp_len));
        chk("ar_id", 64'(axi.ar_id), own_d ? 64'd1 : 64'd0);
        chk("ar_burst", 64'(axi.ar_burst), 64'd1);
        chk("ar_size", 64'(axi.ar_size), 64'd3);
      end
      @(negedge clk);
    end
    axi.ar_ready = 0;
    while (k <= last_idx && cyc < 3000) begin
      if (gaps && $urandom_range(3) == 0) begin
        axi.r_valid = 0;
        #1;
        chk("rvalid_gap", 64'(own_d ? d_rvalid : i_rvalid), 64'd0);
      end else begin
        axi.r_valid = 1;
        axi.r_data  = {$urandom, $urandom};
        axi.r_resp  = (k == err_beat) ? 2'b10 : 2'b00;
        axi.r_last  = (k == last_idx);
        #1;
        chk("r_ready", 64'(axi.r_ready), 64'd1);
        if (own_d ? d_rvalid : i_rvalid) seen++;
        chk("rvalid_other", 64'(own_d ? i_rvalid : d_rvalid), 64'd0);
        chk("rdata", own_d ? d_rdata : i_rdata, axi.r_data);
        chk("rlast", 64'(own_d ? d_rlast : i_rlast), 64'(k == last_idx));
        chk("rerr", 64'(err), 64'((k == last_idx) && exp_err));
        k++;
      end
      cyc++;
      @(negedge clk);
    end
    chk("read_beats", 64'(seen), 64'(exp_beats));
    axi.r_valid = 0; axi.r_last = 0; axi.r_resp = 0;
  endtask

  task automatic serve_write(input logic [63:0] addr, input logic [7:0] len, input int aw_delay,
                             input int b_delay, input logic [1:0] bresp, input bit gaps,
                             input int exp_beats, input bit exp_err);
    int wb, cyc, n_wready;
    bit aw_done;
    wb = 0; cyc = 0; n_wready = 0; aw_done = 0;
    while ((!aw_done || wb <= int'(len)) && cyc < 3000) begin
      axi.aw_ready = !aw_done && cyc >= aw_delay;
      axi.w_ready  = gaps ? ($urandom_range(2) != 0) : 1'b1;
      d_wdata = {$urandom, $urandom};
      d_wstrb = 8'($urandom);
      #1;
      chk("aw_valid", 64'(axi.aw_valid), 64'(!aw_done));
      chk("w_valid", 64'(axi.w_valid), 64'(wb <= int'(len)));
      chk("d_wready", 64'(d_wready), 64'((wb <= int'(len)) && axi.w_ready));
      chk("bdone_early", 64'(d_bdone), 64'd0);
      if (d_wready) n_wready++;
      if (wb <= int'(len)) begin
        chk("w_last", 64'(axi.w_last), 64'(wb == int'(len)));
        chk("w_data", axi.w_data, d_wdata);
        chk("w_strb", 64'(axi.w_strb), 64'(d_wstrb));
      end
      if (axi.aw_ready) begin
        chk("aw_addr", axi.aw_addr, addr);
        chk("aw_len", 64'(axi.aw_len), 64'(len));
        chk("aw_id", 64'(axi.aw_id), 64'd1);
        chk("aw_burst", 64'(axi.aw_burst), 64'd1);
        chk("aw_size", 64'(axi.aw_size), 64'd3);
        aw_done = 1;
      end
      if (wb <= int'(len) && axi.w_ready) wb++;
      cyc++;
      @(negedge clk);
    end
    chk("write_beats", 64'(n_wready), 64'(exp_beats));
    axi.aw_ready = 0; axi.w_ready = 0;
    for (int c = 0; c <= b_delay; c++) begin
      axi.b_valid = (c == b_delay);
      axi.b_resp  = bresp;
      #1;
      chk("b_ready", 64'(axi.b_ready), 64'd1);
      chk("d_bdone", 64'(d_bdone), 64'(c == b_delay));
      chk("berr", 64'(err), 64'((c == b_delay) && exp_err));
      @(negedge clk);
    end
    axi.b_valid = 0; axi.b_resp = 0;
  endtask

  task automatic run_vec(input vec_t v, input bit gaps);
    bit ok;
    request(v.own_d, v.we, v.addr, v.len, ok);
    if (!ok) return;
    if (v.we) serve_write(v.addr, v.len, v.aw_delay, v.b_delay, v.bresp, gaps, v.exp_beats, v.exp_err);
    else      serve_read(v.own_d, v.addr, v.len, v.ar_delay, v.err_beat, v.early, gaps, v.exp_beats, v.exp_err);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok, exp_d;
    vec_t v;
    logic [7:0] rlen;

    axi.ar_ready = 0; axi.aw_ready = 0; axi.w_ready = 0;
    axi.r_id = 0; axi.r_data = 0; axi.r_resp = 0; axi.r_last = 0; axi.r_valid = 0;
    axi.b_id = 0; axi.b_resp = 0; axi.b_valid = 0;

    #2 rst = 0;
    #1;
    chk("rst_ar_valid", 64'(axi.ar_valid), 64'd0);
    chk("rst_aw_valid", 64'(axi.aw_valid), 64'd0);
    chk("rst_w_valid", 64'(axi.w_valid), 64'd0);
    chk("rst_r_ready", 64'(axi.r_ready), 64'd0);
    chk("rst_b_ready", 64'(axi.b_ready), 64'd0);
    chk("rst_pulses", 64'({i_req_ready, d_req_ready, i_rvalid, d_rvalid, d_wready, d_bdone, err}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;
    model_last_d = 1'b1;

    // Three simultaneous i/d read requests; the loser is served right after the winner.
    for (int t = 0; t < 3; t++) begin
`ifdef AXI_SCHED_DPRIO_EN
      exp_d = 1'b1;
`else
      exp_d = ~model_last_d;
`endif
      i_req_valid = 1; i_req_addr = 64'h100 + 64'(t) * 64'h40;
      d_req_valid = 1; d_req_we = 0; d_req_addr = 64'h900 + 64'(t) * 64'h40; d_req_len = 0;
      #1;
      chk("tie_i_ready", 64'(i_req_ready), 64'(!exp_d));
      chk("tie_d_ready", 64'(d_req_ready), 64'(exp_d));
      model_last_d = exp_d;
      @(negedge clk);
      if (exp_d) begin
        d_req_valid = 0;
        serve_read(1, d_req_addr, 8'd0, 0, -1, -1, 0, 1, 0);
        request(0, 0, i_req_addr, 8'd0, ok);
        if (ok) serve_read(0, i_req_addr, 8'd0, 1, -1, -1, 0, 8, 0);
      end else begin
        i_req_valid = 0;
        serve_read(0, i_req_addr, 8'd0, 0, -1, -1, 0, 8, 0);
        request(1, 0, d_req_addr, 8'd0, ok);
        if (ok) serve_read(1, d_req_addr, 8'd0, 0, -1, -1, 0, 1, 0);
      end
    end

    tbl[0]  = '{0, 0, 64'h1000, 8'd0,   2, 0,  0, -1, -1, 2'b00,   8, 0};
    tbl[1]  = '{1, 1, 64'h2040, 8'd7,   0, 13, 2, -1, -1, 2'b00,   8, 0};
    tbl[2]  = '{1, 0, 64'h3000, 8'd3,   1, 0,  0,  1, -1, 2'b00,   4, 1};
    tbl[3]  = '{1, 0, 64'h3040, 8'd3,   0, 0,  0, -1, -1, 2'b00,   4, 0};
    tbl[4]  = '{1, 0, 64'h3080, 8'd3,   0, 0,  0, -1,  1, 2'b00,   2, 1};
    tbl[5]  = '{1, 0, 64'h30c0, 8'd3,   0, 0,  0, -1, -1, 2'b00,   4, 0};
    tbl[6]  = '{1, 0, 64'h4000, 8'd0,   0, 0,  0, -1, -1, 2'b00,   1, 0};
    tbl[7]  = '{1, 1, 64'h5000, 8'd0,   0, 0,  1, -1, -1, 2'b10,   1, 1};
    tbl[8]  = '{1, 0, 64'h6000, 8'd255, 0, 0,  0, -1, -1, 2'b00, 256, 0};
    tbl[9]  = '{1, 1, 64'h7000, 8'd255, 0, 3,  0, -1, -1, 2'b00, 256, 0};
    tbl[10] = '{0, 0, 64'h8000, 8'd0,   0, 0,  0, -1, -1, 2'b00,   8, 0};
    tbl[11] = '{1, 0, 64'h9000, 8'd0,   0, 0,  0,  0, -1, 2'b00,   1, 1};
    for (int i = 0; i < 12; i++) run_vec(tbl[i], 0);

    // Reset asserted in the middle of a d-cache read burst.
    request(1, 0, 64'hA000, 8'd3, ok);
    axi.ar_ready = 1;
    #1;
    chk("mid_ar_valid", 64'(axi.ar_valid), 64'd1);
    @(negedge clk);
    axi.ar_ready = 0;
    axi.r_valid = 1; axi.r_last = 0; axi.r_resp = 0;
    #1;
    chk("mid_rvalid", 64'(d_rvalid), 64'd1);
    @(negedge clk);
    rst = 0;
    #1;
    chk("abort_d_rvalid", 64'(d_rvalid), 64'd0);
    chk("abort_r_ready", 64'(axi.r_ready), 64'd0);
    chk("abort_valids", 64'({axi.ar_valid, axi.aw_valid, axi.w_valid, i_rvalid}), 64'd0);
    axi.r_valid = 0;
    @(negedge clk);
    rst = 1;
    model_last_d = 1'b1;

    // Random traffic against expectations derived from the burst/response rules.
    for (int n = 0; n < 40; n++) begin
      v.own_d    = $urandom_range(1);
      v.we       = v.own_d && ($urandom_range(1) == 1);
      v.addr     = {32'h0, $urandom} & ~64'h3f;
      v.len      = ($urandom_range(7) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(15));
      v.ar_delay = $urandom_range(3);
      v.aw_delay = $urandom_range(10);
      v.b_delay  = $urandom_range(3);
      v.bresp    = ($urandom_range(3) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
      rlen       = v.own_d ? v.len : I_LEN;
      v.err_beat = ($urandom_range(3) == 0) ? int'($urandom_range(int'(rlen))) : -1;
      v.early    = (rlen != 0 && $urandom_range(4) == 0) ? int'($urandom_range(int'(rlen) - 1)) : -1;
      if (v.we) begin
        v.exp_beats = int'(v.len) + 1;
        v.exp_err   = (v.bresp != 2'b00);
      end else begin
        v.exp_beats = ((v.early >= 0) ? v.early : int'(rlen)) + 1;
        v.exp_err   = (v.early >= 0) || (v.err_beat >= 0 && v.err_beat < v.exp_beats);
      end
      run_vec(v, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
